// File: rtl/sar_controller.sv
// ============================================================================
// Module      : sar_controller
// Description : Successive-approximation control FSM that drives an external
//               comparator one trial bit per cycle. Optional early termination
//               on an exact match is enabled with the SAR_EARLY_EXIT_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sar_controller #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         cmp_eq,
    input  logic         cmp_gt,
    output logic [N-1:0] trial,
    output logic [N-1:0] result,
    output logic         busy,
    output logic         done
);

    localparam int              c_IW  = (N > 1) ? $clog2(N) : 1;
    localparam logic [N-1:0]    c_ONE = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N-1:0]    c_MSB = c_ONE << (N - 1);
    localparam logic [c_IW-1:0] c_TOP = c_IW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_TEST = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    logic [N-1:0]    r_trial;
    logic [N-1:0]    r_result;
    logic [c_IW-1:0] r_idx;
    logic            r_busy;
    logic            r_done;

    state_t          w_state_nxt;
    logic [N-1:0]    w_trial_nxt;
    logic [N-1:0]    w_result_nxt;
    logic [c_IW-1:0] w_idx_nxt;
    logic            w_busy_nxt;
    logic            w_done_nxt;

    logic [N-1:0]    w_mask;
    logic            w_keep;
    logic [N-1:0]    w_decided;
    logic            w_early;
    logic            w_last;

    // Decision datapath for the bit currently under test; equality wins over
    // greater-than, but both keep the bit so the priority only matters for
    // the early-exit path.
    assign w_mask    = c_ONE << r_idx;
    assign w_keep    = cmp_eq | cmp_gt;
    assign w_decided = w_keep ? r_trial : (r_trial & ~w_mask);
    assign w_last    = (r_idx == '0);

`ifdef SAR_EARLY_EXIT_EN
    assign w_early = cmp_eq;
`else
    assign w_early = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_trial  <= '0;
            r_result <= '0;
            r_idx    <= c_TOP;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_trial  <= w_trial_nxt;
            r_result <= w_result_nxt;
            r_idx    <= w_idx_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_trial_nxt  = r_trial;
        w_result_nxt = r_result;
        w_idx_nxt    = r_idx;
        w_busy_nxt   = r_busy;
        w_done_nxt   = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_trial_nxt = '0;
                w_busy_nxt  = 1'b0;
                if (start) begin
                    w_state_nxt = S_TEST;
                    w_trial_nxt = c_MSB;
                    w_idx_nxt   = c_TOP;
                    w_busy_nxt  = 1'b1;
                end
            end

            S_TEST: begin
                if (w_last || w_early) begin
                    w_state_nxt  = S_DONE;
                    w_result_nxt = w_decided;
                    w_trial_nxt  = '0;
                    w_idx_nxt    = c_TOP;
                    w_busy_nxt   = 1'b0;
                    w_done_nxt   = 1'b1;
                end else begin
                    // Lower bits are still zero, so OR-ing in the next trial
                    // bit leaves them untouched.
                    w_trial_nxt = w_decided | (w_mask >> 1);
                    w_idx_nxt   = r_idx - 1'b1;
                end
            end

            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_trial_nxt = '0;
                w_busy_nxt  = 1'b0;
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_trial_nxt = '0;
                w_idx_nxt   = c_TOP;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    assign trial  = r_trial;
    assign result = r_result;
    assign busy   = r_busy;
    assign done   = r_done;

endmodule

`default_nettype wire

// File: tb/tb_sar_controller.sv
// ============================================================================
// Module      : tb_sar_controller
// Description : Directed self-checking bench for sar_controller (N = 4) with a
//               behavioural comparator against an analogue value a_val.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sar_controller;

    localparam int N = 4;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         cmp_eq;
    logic         cmp_gt;
    logic [N-1:0] trial;
    logic [N-1:0] result;
    logic         busy;
    logic         done;

    logic [N-1:0] a_val;
    logic         force_eq;
    logic         force_gt;

    int n_checks;
    int n_fail;

    sar_controller #(.N(N)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .cmp_eq (cmp_eq),
        .cmp_gt (cmp_gt),
        .trial  (trial),
        .result (result),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        cmp_eq = force_eq | (a_val == trial);
        cmp_gt = force_gt | (a_val > trial);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Start pulse then ndec decisions; t0..t3 are the expected trial codes.
    task automatic run_conv(input string tag, input logic [N-1:0] a, input int ndec,
                            input int t0, input int t1, input int t2, input int t3,
                            input int res);
        int tt[4];
        tt[0] = t0; tt[1] = t1; tt[2] = t2; tt[3] = t3;
        a_val = a;
        start = 1'b1;
        step();
        start = 1'b0;
        check({tag, "_trial0"}, 32'(trial), 32'(tt[0]));
        check({tag, "_busy0"}, 32'(busy), 32'd1);
        for (int i = 1; i < ndec; i++) begin
            step();
            check($sformatf("%s_trial%0d", tag, i), 32'(trial), 32'(tt[i]));
            check($sformatf("%s_busy%0d", tag, i), 32'(busy), 32'd1);
            check($sformatf("%s_done%0d", tag, i), 32'(done), 32'd0);
        end
        step();
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_result"}, 32'(result), 32'(res));
        check({tag, "_trial_end"}, 32'(trial), 32'd0);
        check({tag, "_busy_end"}, 32'(busy), 32'd0);
        step();
        check({tag, "_done_drop"}, 32'(done), 32'd0);
        check({tag, "_result_hold"}, 32'(result), 32'(res));
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        start    = 1'b1;
        a_val    = '0;
        force_eq = 1'b0;
        force_gt = 1'b0;

        // Reset with start asserted must not launch a conversion
        step();
        step();
        check("rst_trial", 32'(trial), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        start = 1'b0;
        rst_n = 1'b1;
        step();
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_trial", 32'(trial), 32'd0);

        run_conv("a11", 4'd11, 4, 8, 12, 10, 11, 11);
`ifdef SAR_EARLY_EXIT_EN
        run_conv("a8", 4'd8, 1, 8, 0, 0, 0, 8);
`else
        run_conv("a8", 4'd8, 4, 8, 12, 10, 9, 8);
`endif
        run_conv("a0", 4'd0, 4, 8, 4, 2, 1, 0);
        run_conv("a15", 4'd15, 4, 8, 12, 14, 15, 15);

        // start held high: done at cycles 4, 10, 16 after the first start edge
        a_val = 4'd5;
        start = 1'b1;
        step();
        check("b2b_trial0", 32'(trial), 32'd8);
        for (int i = 1; i <= 16; i++) begin
            step();
            if (i == 1) check("b2b_trial1", 32'(trial), 32'd4);
            check($sformatf("b2b_done_c%0d", i), 32'(done), ((i % 6) == 4) ? 32'd1 : 32'd0);
            if ((i % 6) == 4) check($sformatf("b2b_result_c%0d", i), 32'(result), 32'd5);
        end
        start = 1'b0;
        step();
        step();
        check("b2b_idle", 32'(busy), 32'd0);

        // Reset asserted on the second TEST edge
        a_val = 4'd11;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        check("midrst_trial_pre", 32'(trial), 32'd12);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("midrst_trial", 32'(trial), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_result", 32'(result), 32'd0);
        for (int i = 0; i < 6; i++) begin
            step();
            check($sformatf("midrst_nodone%0d", i), 32'(done), 32'd0);
        end

        // Both comparator flags forced on the first trial with A=3
        a_val = 4'd3;
        start = 1'b1;
        step();
        start    = 1'b0;
        force_eq = 1'b1;
        force_gt = 1'b1;
        check("force_trial0", 32'(trial), 32'd8);
        step();
        force_eq = 1'b0;
        force_gt = 1'b0;
`ifdef SAR_EARLY_EXIT_EN
        check("force_done", 32'(done), 32'd1);
        check("force_result", 32'(result), 32'd8);
`else
        check("force_trial1", 32'(trial), 32'd12);
        step();
        check("force_trial2", 32'(trial), 32'd10);
        step();
        check("force_trial3", 32'(trial), 32'd9);
        step();
        check("force_done", 32'(done), 32'd1);
        check("force_result", 32'(result), 32'd8);
`endif
        step();
        check("force_done_drop", 32'(done), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sar_controller.md
SAR_CONTROLLER -- requirements
Module: sar_controller

Interface
- REQ-001: Parameter N, default 4: conversion width in bits; legal range 2..16.
- REQ-002: clk  input  1  sole clock; all state updates on rising edge.
- REQ-003: rst_n  input  1  reset, synchronous and active-low.
- REQ-004: start  input  1  conversion request, sampled only in IDLE.
- REQ-005: cmp_eq  input  1  external comparator flag: sampled input equals trial.
- REQ-006: cmp_gt  input  1  external comparator flag: sampled input greater than trial.
- REQ-007: trial  output  N  trial code driven to the external comparator's B operand.
- REQ-008: result  output  N  converted code; valid from done until the next accepted start.
- REQ-009: busy  output  1  high while a conversion is in progress.
- REQ-010: done  output  1  one-cycle pulse marking result valid.

Function
- REQ-011: FSM states: IDLE, TEST, DONE; registered state, registered outputs.
- REQ-012: IDLE with start=1 at edge k: enter TEST with trial = 1 << (N-1), bit index = N-1, busy = 1.
- REQ-013: start=0 in IDLE: remain in IDLE; start in TEST or DONE: ignored, no queuing.
- REQ-014: External comparator is combinational; cmp_eq/cmp_gt reflect the current trial within the same cycle.
- REQ-015: TEST, one decision per edge: current bit kept if cmp_eq=1 or cmp_gt=1, else cleared.
- REQ-016: cmp_eq has priority; cmp_eq=1 with cmp_gt=1 is treated as equal.
- REQ-017: After a decision on bit i>0: set bit i-1 in trial; lower bits remain 0; stay in TEST.
- REQ-018: After the decision on bit 0: result <= decided code, trial <= 0, busy <= 0, enter DONE.
- REQ-019: DONE lasts exactly one cycle with done=1, then IDLE; done is 0 in all other states.
- REQ-020: Full conversion latency: start sampled at edge k; done high in the cycle after edge k+N.
- REQ-021: trial = 0 in IDLE and DONE; result holds its value until overwritten at the end of the next conversion.
- REQ-022: start held continuously high: a new conversion begins at the first edge in IDLE after DONE, giving an N+2 cycle period.

Reset
- REQ-023: rst_n=0 at any edge, including mid-conversion: state=IDLE, trial=0, result=0, busy=0, done=0, bit index=N-1.
- REQ-024: No conversion is started on the edge where rst_n=0, regardless of start.

Configuration
- REQ-025: Macro SAR_EARLY_EXIT_EN selects early termination.
- REQ-026: SAR_EARLY_EXIT_EN defined: cmp_eq=1 in TEST ends the conversion on that edge; result = current trial and DONE is entered, so latency = number of decisions made + 1.
- REQ-027: SAR_EARLY_EXIT_EN undefined: cmp_eq only keeps the bit; all N decisions always occur; the final result is identical to the early-exit case.

Verification (N=4, bench comparator model uses input value A against trial)
- REQ-028: A=11, start pulse: trials 8,12,10,11; result=11; done in the cycle after edge k+4; busy high for 4 cycles.
- REQ-029: A=8: with SAR_EARLY_EXIT_EN, done in the cycle after edge k+1 and result=8; without it, trials 8,12,10,9, done after edge k+4, result=8.
- REQ-030: A=0 gives result=0; A=15 gives result=15 with trials 8,12,14,15.
- REQ-031: start held high, A=5: back-to-back conversions, result=5 each time, done period = 6 cycles; start pulses during TEST are ignored.
- REQ-032: rst_n=0 at the second TEST edge: next cycle has trial=0, busy=0, done=0, result=0; no done pulse follows.
- REQ-033: cmp_eq=1 and cmp_gt=1 forced together on the first trial: bit 3 kept, and early exit occurs if SAR_EARLY_EXIT_EN is defined.
